// File: rtl/backend_pkg.sv
// Shared out-of-order backend definitions: width helpers, ROB entry layout
// and the packed-bus slicing macro used by the CDB, RAT and issuer.
`ifndef BACKEND_PKG_SV
`define BACKEND_PKG_SV

// Slot idx of a packed bus of w-bit lanes, lane 0 in the LSBs.
`define BUS_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package backend_pkg;

   function automatic int unsigned rob_entry_log2(input int unsigned n);
      return $clog2(n);
   endfunction

   function automatic int unsigned arch_entry_log2(input int unsigned n);
      return $clog2(n);
   endfunction

   // ROB entry word: flag bits at the bottom, then arch_id, then data.
   localparam int unsigned ENT_VALID    = 0;
   localparam int unsigned ENT_DONE     = 1;
   localparam int unsigned ENT_ARCH_LSB = 2;

   function automatic int unsigned ent_data_lsb(input int unsigned arch_w);
      return ENT_ARCH_LSB + arch_w;
   endfunction

   function automatic int unsigned ent_width(input int unsigned arch_w,
                                             input int unsigned data_w);
      return ENT_ARCH_LSB + arch_w + data_w;
   endfunction

endpackage

`endif

// File: rtl/rob_commit_select.sv
// Contiguous-prefix retire selection over head-relative valid/done vectors.
module rob_commit_select #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned CNT_W = 4
) (
   input  logic             enable,
   input  logic [WIDTH-1:0] rel_valid,
   input  logic [WIDTH-1:0] rel_done,
   output logic [WIDTH-1:0] commit_valid,
   output logic [CNT_W-1:0] retire_cnt
);

   logic run;

   always_comb begin
      run          = enable;
      commit_valid = '0;
      retire_cnt   = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         run             = run & rel_valid[k] & rel_done[k];
         commit_valid[k] = run;
         retire_cnt      = retire_cnt + CNT_W'(run);
      end
   end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-port write-back, multi-commit reorder buffer with single-cycle flush.
`include "backend_pkg.sv"

module reorder_buffer_mc
   import backend_pkg::*;
#(
   parameter int unsigned ROB_ENTRY    = 8,
   parameter int unsigned ARCH_ENTRY   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned WB_PORTS     = 2,
   parameter int unsigned COMMIT_WIDTH = 2,
   localparam int unsigned ROB_ENTRY_LOG2  = rob_entry_log2(ROB_ENTRY),
   localparam int unsigned ARCH_ENTRY_LOG2 = arch_entry_log2(ARCH_ENTRY)
) (
   input  logic                                    CLK,
   input  logic                                    RST,
   input  logic                                    alloc_request,
   input  logic [ARCH_ENTRY_LOG2-1:0]              alloc_arch_id,
   output logic                                    alloc_grant,
   output logic [ROB_ENTRY_LOG2-1:0]               alloc_alias_id,
   input  logic [WB_PORTS-1:0]                     wb_valid,
   input  logic [WB_PORTS*ROB_ENTRY_LOG2-1:0]      wb_id,
   input  logic [WB_PORTS*DATA_WIDTH-1:0]          wb_data,
   input  logic                                    commit_ready,
   output logic [COMMIT_WIDTH-1:0]                 commit_valid,
   output logic [COMMIT_WIDTH*ARCH_ENTRY_LOG2-1:0] commit_arch_id,
   output logic [COMMIT_WIDTH*ROB_ENTRY_LOG2-1:0]  commit_alias,
   output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]      commit_data,
   input  logic                                    flush,
   output logic [ROB_ENTRY_LOG2:0]                 rob_count,
   output logic                                    rob_full,
   output logic                                    rob_empty
);

   localparam int unsigned PW           = ROB_ENTRY_LOG2 + 1;
   localparam int unsigned ENT_DATA_LSB = ent_data_lsb(ARCH_ENTRY_LOG2);
   localparam int unsigned ENT_W        = ent_width(ARCH_ENTRY_LOG2, DATA_WIDTH);

   logic [ENT_W-1:0]          ent [ROB_ENTRY];
   logic [PW-1:0]             head;
   logic [PW-1:0]             tail;
   logic [ROB_ENTRY_LOG2-1:0] tail_idx;
   logic [ROB_ENTRY_LOG2-1:0] rel_idx [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]   rel_valid;
   logic [COMMIT_WIDTH-1:0]   rel_done;
   logic [PW-1:0]             retire_cnt;
   logic [ROB_ENTRY_LOG2-1:0] wb_idx [WB_PORTS];
   logic [DATA_WIDTH-1:0]     wb_val [WB_PORTS];

   assign tail_idx       = tail[ROB_ENTRY_LOG2-1:0];
   assign alloc_alias_id = tail_idx;
   assign rob_empty      = (head == tail);
   assign rob_full       = (head[ROB_ENTRY_LOG2-1:0] == tail_idx) &&
                           (head[ROB_ENTRY_LOG2] != tail[ROB_ENTRY_LOG2]);
   assign rob_count      = tail - head;
   assign alloc_grant    = alloc_request & ~rob_full & ~flush;

   always_comb begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
         wb_idx[p] = `BUS_SLICE(wb_id, p, ROB_ENTRY_LOG2);
         wb_val[p] = `BUS_SLICE(wb_data, p, DATA_WIDTH);
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         rel_idx[k]   = head[ROB_ENTRY_LOG2-1:0] + ROB_ENTRY_LOG2'(k);
         rel_valid[k] = ent[rel_idx[k]][ENT_VALID];
         rel_done[k]  = ent[rel_idx[k]][ENT_DONE];
      end
   end

   rob_commit_select #(
      .WIDTH (COMMIT_WIDTH),
      .CNT_W (PW)
   ) u_commit_select (
      .enable       (~flush),
      .rel_valid    (rel_valid),
      .rel_done     (rel_done),
      .commit_valid (commit_valid),
      .retire_cnt   (retire_cnt)
   );

   always_comb begin
      commit_arch_id = '0;
      commit_alias   = '0;
      commit_data    = '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         if (commit_valid[k]) begin
            `BUS_SLICE(commit_arch_id, k, ARCH_ENTRY_LOG2) = ent[rel_idx[k]][ENT_ARCH_LSB +: ARCH_ENTRY_LOG2];
            `BUS_SLICE(commit_alias, k, ROB_ENTRY_LOG2)    = rel_idx[k];
            `BUS_SLICE(commit_data, k, DATA_WIDTH)         = ent[rel_idx[k]][ENT_DATA_LSB +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head <= '0;
         tail <= '0;
         for (int unsigned i = 0; i < ROB_ENTRY; i++) ent[i] <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         for (int unsigned i = 0; i < ROB_ENTRY; i++) begin
            ent[i][ENT_VALID] <= 1'b0;
            ent[i][ENT_DONE]  <= 1'b0;
         end
      end else begin
         if (alloc_grant) begin
            ent[tail_idx][ENT_VALID]                         <= 1'b1;
            ent[tail_idx][ENT_DONE]                          <= 1'b0;
            ent[tail_idx][ENT_ARCH_LSB +: ARCH_ENTRY_LOG2]   <= alloc_arch_id;
            tail                                             <= tail + PW'(1);
         end
         // Highest port is written first so the lowest port lands last and wins a shared id.
         for (int unsigned i = 0; i < WB_PORTS; i++) begin
            if (wb_valid[WB_PORTS-1-i] && ent[wb_idx[WB_PORTS-1-i]][ENT_VALID]) begin
               ent[wb_idx[WB_PORTS-1-i]][ENT_DONE]                      <= 1'b1;
               ent[wb_idx[WB_PORTS-1-i]][ENT_DATA_LSB +: DATA_WIDTH]    <= wb_val[WB_PORTS-1-i];
            end
         end
         if (commit_ready) begin
            for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
               if (commit_valid[k]) begin
                  ent[rel_idx[k]][ENT_VALID] <= 1'b0;
                  ent[rel_idx[k]][ENT_DONE]  <= 1'b0;
               end
            end
            head <= head + retire_cnt;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: allocations push expected commits,
// a negedge monitor pops and compares every retirement.
module tb_reorder_buffer_mc;

   logic        CLK = 1'b0;
   logic        RST;
   logic        alloc_request;
   logic [4:0]  alloc_arch_id;
   logic        alloc_grant;
   logic [2:0]  alloc_alias_id;
   logic [1:0]  wb_valid;
   logic [5:0]  wb_id;
   logic [63:0] wb_data;
   logic        commit_ready;
   logic [1:0]  commit_valid;
   logic [9:0]  commit_arch_id;
   logic [5:0]  commit_alias;
   logic [63:0] commit_data;
   logic        flush;
   logic [3:0]  rob_count;
   logic        rob_full;
   logic        rob_empty;

   typedef struct {
      logic [2:0] alias_id;
      logic [4:0] arch;
   } exp_t;

   exp_t        sb [$];
   logic [2:0]  pw [$];
   logic [31:0] exp_data [8];
   exp_t        e;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [2:0]  exp_tail;
   logic [2:0]  a, b;

   reorder_buffer_mc #(
      .ROB_ENTRY    (8),
      .ARCH_ENTRY   (32),
      .DATA_WIDTH   (32),
      .WB_PORTS     (2),
      .COMMIT_WIDTH (2)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .alloc_request  (alloc_request),
      .alloc_arch_id  (alloc_arch_id),
      .alloc_grant    (alloc_grant),
      .alloc_alias_id (alloc_alias_id),
      .wb_valid       (wb_valid),
      .wb_id          (wb_id),
      .wb_data        (wb_data),
      .commit_ready   (commit_ready),
      .commit_valid   (commit_valid),
      .commit_arch_id (commit_arch_id),
      .commit_alias   (commit_alias),
      .commit_data    (commit_data),
      .flush          (flush),
      .rob_count      (rob_count),
      .rob_full       (rob_full),
      .rob_empty      (rob_empty)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [2:0] al, input logic [4:0] ar);
      exp_t x;
      x.alias_id = al;
      x.arch     = ar;
      sb.push_back(x);
   endtask

   task automatic drive_wb(input logic [1:0] v, input logic [2:0] id0, input logic [31:0] d0,
                           input logic [2:0] id1, input logic [31:0] d1);
      wb_valid = v;
      wb_id    = {id1, id0};
      wb_data  = {d1, d0};
   endtask

   always @(negedge CLK) begin
      if (!RST && commit_ready) begin
         for (int k = 0; k < 2; k++) begin
            if (commit_valid[k]) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_commit: slot %0d alias %0d, expected no retirement (t=%0t)",
                           k, commit_alias[k*3 +: 3], $time);
               end else begin
                  e = sb.pop_front();
                  chk("commit_alias", 64'(commit_alias[k*3 +: 3]), 64'(e.alias_id));
                  chk("commit_arch", 64'(commit_arch_id[k*5 +: 5]), 64'(e.arch));
                  chk("commit_data", 64'(commit_data[k*32 +: 32]), 64'(exp_data[e.alias_id]));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; alloc_request = 1'b0; alloc_arch_id = '0; flush = 1'b0;
      wb_valid = '0; wb_id = '0; wb_data = '0; commit_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_data[i] = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_grant", 64'(alloc_grant), 64'(0));
      chk("rst_alias", 64'(alloc_alias_id), 64'(0));
      chk("rst_commit_valid", 64'(commit_valid), 64'(0));
      chk("rst_commit_arch", 64'(commit_arch_id), 64'(0));
      chk("rst_commit_alias", 64'(commit_alias), 64'(0));
      chk("rst_commit_data", commit_data, 64'(0));
      chk("rst_count", 64'(rob_count), 64'(0));
      chk("rst_empty", 64'(rob_empty), 64'(1));
      chk("rst_full", 64'(rob_full), 64'(0));
      RST = 1'b0;

      // Fill: 8 grants with aliases 0..7, then a refused 9th request.
      for (int i = 0; i < 8; i++) begin
         tick();
         alloc_request = 1'b1;
         alloc_arch_id = 5'(i + 1);
         #1;
         chk("fill_grant", 64'(alloc_grant), 64'(1));
         chk("fill_alias", 64'(alloc_alias_id), 64'(i));
         push_exp(3'(i), 5'(i + 1));
      end
      tick();
      alloc_arch_id = 5'd9;
      #1;
      chk("full_flag", 64'(rob_full), 64'(1));
      chk("full_count", 64'(rob_count), 64'(8));
      chk("full_no_grant", 64'(alloc_grant), 64'(0));
      alloc_request = 1'b0;

      // Two ports write ids 1 and 0; both retire together a cycle later.
      tick();
      drive_wb(2'b11, 3'd1, 32'h11, 3'd0, 32'h10);
      exp_data[1] = 32'h11;
      exp_data[0] = 32'h10;
      #1;
      chk("wb_no_same_cycle_commit", 64'(commit_valid), 64'(0));
      tick();
      wb_valid = '0;
      #1;
      chk("dual_commit_valid", 64'(commit_valid), 64'(2'b11));
      chk("dual_commit_count", 64'(rob_count), 64'(8));
      tick();
      chk("count_after_dual", 64'(rob_count), 64'(6));
      chk("not_full_after_dual", 64'(rob_full), 64'(0));

      // Entry past the head completes first: nothing retires until the head does.
      drive_wb(2'b01, 3'd3, 32'h33, 3'd0, 32'h0);
      exp_data[3] = 32'h33;
      tick();
      drive_wb(2'b01, 3'd2, 32'h22, 3'd0, 32'h0);
      exp_data[2] = 32'h22;
      #1;
      chk("head_not_done", 64'(commit_valid), 64'(0));
      tick();
      wb_valid = '0;
      #1;
      chk("head_done_pair", 64'(commit_valid), 64'(2'b11));
      tick();
      chk("count_after_pair", 64'(rob_count), 64'(4));

      // Both ports target id 5: port 0 data must be kept.
      drive_wb(2'b11, 3'd5, 32'hAAAA, 3'd5, 32'h5555);
      exp_data[5] = 32'hAAAA;
      #1;
      chk("conflict_no_commit", 64'(commit_valid), 64'(0));
      tick();
      drive_wb(2'b01, 3'd4, 32'h44, 3'd0, 32'h0);
      exp_data[4] = 32'h44;
      #1;
      chk("conflict_head_pending", 64'(commit_valid), 64'(0));
      tick();
      wb_valid = '0;
      #1;
      chk("conflict_commit_valid", 64'(commit_valid), 64'(2'b11));
      tick();
      chk("count_after_conflict", 64'(rob_count), 64'(2));

      // Wrap allocation to 5 live entries with retirement stalled, then flush.
      commit_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alloc_request = 1'b1;
         alloc_arch_id = 5'(10 + i);
         #1;
         chk("wrap_grant", 64'(alloc_grant), 64'(1));
         chk("wrap_alias", 64'(alloc_alias_id), 64'(i));
         push_exp(3'(i), 5'(10 + i));
         tick();
      end
      alloc_request = 1'b0;
      drive_wb(2'b11, 3'd6, 32'h66, 3'd7, 32'h77);
      exp_data[6] = 32'h66;
      exp_data[7] = 32'h77;
      tick();
      wb_valid = '0;
      #1;
      chk("stall_commit_valid", 64'(commit_valid), 64'(2'b11));
      chk("stall_count", 64'(rob_count), 64'(5));
      tick();
      chk("hold_commit_valid", 64'(commit_valid), 64'(2'b11));
      chk("hold_count", 64'(rob_count), 64'(5));
      tick();
      flush = 1'b1;
      commit_ready = 1'b1;
      alloc_request = 1'b1;
      alloc_arch_id = 5'd14;
      drive_wb(2'b01, 3'd0, 32'h99, 3'd0, 32'h0);
      sb.delete();
      #1;
      chk("flush_no_grant", 64'(alloc_grant), 64'(0));
      chk("flush_no_commit", 64'(commit_valid), 64'(0));
      tick();
      flush = 1'b0;
      alloc_request = 1'b0;
      wb_valid = '0;
      #1;
      chk("post_flush_empty", 64'(rob_empty), 64'(1));
      chk("post_flush_count", 64'(rob_count), 64'(0));
      alloc_request = 1'b1;
      alloc_arch_id = 5'd13;
      #1;
      chk("empty_alloc_no_commit", 64'(commit_valid), 64'(0));
      chk("post_flush_grant", 64'(alloc_grant), 64'(1));
      chk("post_flush_alias", 64'(alloc_alias_id), 64'(0));
      push_exp(3'd0, 5'd13);
      pw.push_back(3'd0);
      exp_tail = 3'd1;
      tick();

      // Streaming: one alloc per cycle, pairs written back every other cycle.
      for (int r = 0; r < 20; r++) begin
         wb_valid = '0;
         if ((r % 2 == 0) && (pw.size() >= 2)) begin
            a = pw.pop_front();
            b = pw.pop_front();
            drive_wb(2'b11, a, 32'hA000_0000 + 32'(r), b, 32'hB000_0000 + 32'(r));
            exp_data[a] = 32'hA000_0000 + 32'(r);
            exp_data[b] = 32'hB000_0000 + 32'(r);
         end
         alloc_request = 1'b1;
         alloc_arch_id = 5'(r + 1);
         #1;
         chk("stream_grant", 64'(alloc_grant), 64'(1));
         chk("stream_alias", 64'(alloc_alias_id), 64'(exp_tail));
         chk("stream_count_bound", 64'(rob_count <= 4'd8), 64'(1));
         push_exp(exp_tail, 5'(r + 1));
         pw.push_back(exp_tail);
         exp_tail = exp_tail + 3'd1;
         tick();
      end
      alloc_request = 1'b0;
      wb_valid = '0;
      while (pw.size() > 0) begin
         a = pw.pop_front();
         drive_wb(2'b01, a, 32'hC000_0000 + 32'(a), 3'd0, 32'h0);
         exp_data[a] = 32'hC000_0000 + 32'(a);
         tick();
      end
      wb_valid = '0;
      for (int c = 0; c < 20; c++) begin
         if (sb.size() == 0) break;
         tick();
      end
      chk("drain_outstanding", 64'(sb.size()), 64'(0));
      #1;
      chk("drain_empty", 64'(rob_empty), 64'(1));
      chk("drain_count", 64'(rob_count), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
